// File: rtl/prio_encoder_seq.sv
// Registered priority encoder with sticky request capture, valid/ready output
// and optional round-robin priority rotation.
module prio_encoder_seq #(
   parameter int WIDTH   = 8,
   parameter int RR_MODE = 0,
   localparam int IDX_W  = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] req_in,
   input  logic             out_ready,
   output logic             out_valid,
   output logic [IDX_W-1:0] out_idx,
   output logic [WIDTH-1:0] pending,
   output logic             overflow
);

   localparam logic [IDX_W-1:0] PTR_TOP  = IDX_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [IDX_W-1:0] ptr_r;
   logic             load_s;
   logic [IDX_W-1:0] fix_idx_s;
   logic [IDX_W-1:0] rr_idx_s;
   logic [IDX_W-1:0] grant_idx_s;
   logic [WIDTH-1:0] grant_mask_s;
   logic [IDX_W-1:0] next_ptr_s;
   int               cand_s;

   // Fixed priority: ascending scan, so the highest set index is written last.
   always_comb begin
      fix_idx_s = {IDX_W{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         fix_idx_s = pending[i] ? IDX_W'(i) : fix_idx_s;
      end
   end

   // Round-robin: candidates nearest below ptr (with wrap) are written last.
   always_comb begin
      rr_idx_s = {IDX_W{1'b0}};
      cand_s   = 0;
      for (int off = WIDTH - 1; off >= 0; off--) begin
         cand_s = int'(ptr_r) - off;
         if (cand_s < 0) begin
            cand_s = cand_s + WIDTH;
         end else begin
            cand_s = cand_s;
         end
         rr_idx_s = pending[IDX_W'(cand_s)] ? IDX_W'(cand_s) : rr_idx_s;
      end
   end

   // Load decision, grant selection and pointer update.
   always_comb begin
      load_s       = (!out_valid || out_ready) && (pending != {WIDTH{1'b0}});
      grant_idx_s  = (RR_MODE != 0) ? rr_idx_s : fix_idx_s;
      grant_mask_s = {WIDTH{1'b0}};
      next_ptr_s   = ptr_r;
      if (load_s) begin
         grant_mask_s = ONE_HOT0 << grant_idx_s;
         if (RR_MODE != 0) begin
            next_ptr_s = (grant_idx_s == {IDX_W{1'b0}}) ? PTR_TOP
                                                        : grant_idx_s - IDX_W'(1);
         end else begin
            next_ptr_s = ptr_r;
         end
      end else begin
         grant_mask_s = {WIDTH{1'b0}};
         next_ptr_s   = ptr_r;
      end
   end

   // State and output registers; a request on the granted bit re-sets it.
   always_ff @(posedge clk) begin
      if (reset) begin
         pending   <= {WIDTH{1'b0}};
         out_valid <= 1'b0;
         out_idx   <= {IDX_W{1'b0}};
         overflow  <= 1'b0;
         ptr_r     <= PTR_TOP;
      end else begin
         pending  <= (pending & ~grant_mask_s) | req_in;
         overflow <= |(req_in & pending & ~grant_mask_s);
         ptr_r    <= next_ptr_s;
         if (load_s) begin
            out_idx   <= grant_idx_s;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_prio_encoder_seq.sv
// Scoreboard bench: fixed-priority and round-robin instances with directed vectors.
module tb_prio_encoder_seq;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] req0, req1;
   logic       rdy0, rdy1;
   logic       ov0, ov1;
   logic [2:0] oi0, oi1;
   logic [7:0] pend0, pend1;
   logic       ovf0, ovf1;

   int checks = 0;
   int errors = 0;
   int q0[$];
   int q1[$];

   always #5 clk = ~clk;

   prio_encoder_seq #(.WIDTH(8), .RR_MODE(0)) dut_fix (
      .clk(clk), .reset(reset), .req_in(req0), .out_ready(rdy0),
      .out_valid(ov0), .out_idx(oi0), .pending(pend0), .overflow(ovf0));

   prio_encoder_seq #(.WIDTH(8), .RR_MODE(1)) dut_rr (
      .clk(clk), .reset(reset), .req_in(req1), .out_ready(rdy1),
      .out_valid(ov1), .out_idx(oi1), .pending(pend1), .overflow(ovf1));

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted handshake is popped from the matching scoreboard.
   task automatic monitor();
      int e;
      forever begin
         @(negedge clk);
         if (!reset && ov0 && rdy0) begin
            checks++;
            if (q0.size() == 0) begin
               errors++;
               $display("FAIL fix_unexpected_grant: got %0d expected none", oi0);
            end else begin
               e = q0.pop_front();
               if (int'(oi0) != e) begin
                  errors++;
                  $display("FAIL fix_grant: got %0d expected %0d", oi0, e);
               end
            end
         end
         if (!reset && ov1 && rdy1) begin
            checks++;
            if (q1.size() == 0) begin
               errors++;
               $display("FAIL rr_unexpected_grant: got %0d expected none", oi1);
            end else begin
               e = q1.pop_front();
               if (int'(oi1) != e) begin
                  errors++;
                  $display("FAIL rr_grant: got %0d expected %0d", oi1, e);
               end
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; req0 = 8'hFF; req1 = 8'hFF; rdy0 = 1'b1; rdy1 = 1'b1;
      fork
         monitor();
      join_none

      // Reset held 3 cycles with all requests high
      repeat (3) cyc();
      reset = 1'b0; req0 = 8'h00; req1 = 8'h00;
      chk("rst_pending", 32'(pend0), 32'h00);
      chk("rst_valid", 32'(ov0), 32'h0);
      chk("rst_idx", 32'(oi0), 32'h0);
      chk("rst_overflow", 32'(ovf0), 32'h0);
      chk("rst_rr_pending", 32'(pend1), 32'h00);
      chk("rst_rr_valid", 32'(ov1), 32'h0);
      repeat (2) cyc();
      chk("rst_no_grant", 32'(ov0), 32'h0);
      chk("rst_rr_no_grant", 32'(ov1), 32'h0);

      // Fixed order 7,5,2
      q0.push_back(7); q0.push_back(5); q0.push_back(2);
      req0 = 8'hA4;
      cyc();
      req0 = 8'h00;
      chk("fo_pend1", 32'(pend0), 32'hA4);
      chk("fo_valid1", 32'(ov0), 32'h0);
      cyc();
      chk("fo_pend2", 32'(pend0), 32'h24);
      chk("fo_idx2", 32'(oi0), 32'h7);
      cyc();
      chk("fo_pend3", 32'(pend0), 32'h04);
      cyc();
      chk("fo_pend4", 32'(pend0), 32'h00);
      chk("fo_valid4", 32'(ov0), 32'h1);
      cyc();
      chk("fo_release", 32'(ov0), 32'h0);

      // Backpressure
      rdy0 = 1'b0;
      q0.push_back(7); q0.push_back(5); q0.push_back(2);
      req0 = 8'hA4;
      cyc();
      req0 = 8'h00;
      cyc();
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("bp_idx", 32'(oi0), 32'h7);
         chk("bp_valid", 32'(ov0), 32'h1);
         chk("bp_pend", 32'(pend0), 32'h24);
      end
      rdy0 = 1'b1;
      cyc();
      chk("bp_idx5", 32'(oi0), 32'h5);
      cyc();
      chk("bp_idx2", 32'(oi0), 32'h2);
      cyc();
      chk("bp_release", 32'(ov0), 32'h0);

      // Overflow merge while stalled on a grant of 0
      rdy0 = 1'b0;
      q0.push_back(0); q0.push_back(3);
      req0 = 8'h01;
      cyc();
      req0 = 8'h00;
      cyc();
      chk("om_stall_valid", 32'(ov0), 32'h1);
      req0 = 8'h08;
      cyc();
      chk("om_first_ovf", 32'(ovf0), 32'h0);
      cyc();
      req0 = 8'h00;
      chk("om_ovf", 32'(ovf0), 32'h1);
      chk("om_pend", 32'(pend0), 32'h08);
      cyc();
      chk("om_ovf_pulse", 32'(ovf0), 32'h0);
      chk("om_pend_hold", 32'(pend0), 32'h08);
      rdy0 = 1'b1;
      repeat (4) cyc();
      chk("om_release", 32'(ov0), 32'h0);
      chk("om_pend_clear", 32'(pend0), 32'h00);

      // Mode contrast: 8'h81 held on both instances
      for (int i = 0; i < 6; i++) q0.push_back(7);
      q0.push_back(0);
      for (int i = 0; i < 7; i++) q1.push_back((i % 2 == 0) ? 7 : 0);
      req0 = 8'h81; req1 = 8'h81;
      cyc();
      chk("mc_ovf_first", 32'(ovf0), 32'h0);
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("mc_fix_ovf", 32'(ovf0), 32'h1);
         chk("mc_rr_ovf", 32'(ovf1), 32'h1);
         chk("mc_fix_starve", 32'(pend0), 32'h81);
      end
      req0 = 8'h00; req1 = 8'h00;
      repeat (3) cyc();
      chk("mc_fix_done", 32'(ov0), 32'h0);
      chk("mc_rr_done", 32'(ov1), 32'h0);

      // Reset mid-operation; the held grant of 6 is discarded
      rdy0 = 1'b0;
      req0 = 8'h4F;
      cyc();
      req0 = 8'h00;
      cyc();
      chk("rm_pend", 32'(pend0), 32'h0F);
      chk("rm_idx", 32'(oi0), 32'h6);
      chk("rm_valid", 32'(ov0), 32'h1);
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      chk("rm_pend_rst", 32'(pend0), 32'h00);
      chk("rm_valid_rst", 32'(ov0), 32'h0);
      chk("rm_idx_rst", 32'(oi0), 32'h0);
      chk("rm_ovf_rst", 32'(ovf0), 32'h0);
      rdy0 = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         chk("rm_no_grant", 32'(ov0), 32'h0);
      end

      chk("sb_fix_empty", 32'(q0.size()), 32'h0);
      chk("sb_rr_empty", 32'(q1.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/prio_encoder_seq.md
# prio_encoder_seq

Parametrised, registered priority encoder with sticky request capture and a valid/ready output handshake. It generalises the fixed 4-input combinational encoder to WIDTH request lines and adds a round-robin mode. Request pulses are held until each one has been encoded and accepted downstream. It sits between asynchronous-style event/request lines and any consumer that takes one encoded index per cycle.

## Interface
- WIDTH, 8: number of request lines; at least 2.
- RR_MODE, 0: 0 = fixed priority, highest index wins; 1 = rotating round-robin priority.
- IDX_W, $clog2(WIDTH): localparam, width of the encoded index.

- clk  in  1  rising-edge clock; the block uses only this clock.
- reset  in  1  synchronous, active-high reset.
- req_in  in  WIDTH  request lines; each high bit in a cycle is one request event.
- out_ready  in  1  consumer accepts out_idx on an edge where out_valid and out_ready are both high.
- out_valid  out  1  out_idx holds a granted index.
- out_idx  out  IDX_W  encoded index of the granted request.
- pending  out  WIDTH  captured requests not yet granted (debug/status).
- overflow  out  1  one-cycle pulse: a request arrived on a line already pending and was merged.

## Operation
- **Capture.** On each edge, next pending = (pending & ~grant_mask) | req_in.
  - A new request on the bit being granted in that same edge sets the bit again; set wins over clear.
- **Load condition.** The output register loads when (!out_valid || out_ready) and pending != 0.
  - The search uses registered pending only; req_in in the same cycle is not considered.
- **Fixed mode (RR_MODE=0).** The highest set index of pending is granted.
- **Round-robin mode (RR_MODE=1).**
  - Pointer ptr (IDX_W bits) marks the highest-priority index.
  - The search runs descending from ptr and wraps from 0 to WIDTH-1.
  - After granting k, ptr becomes k-1; after granting 0, ptr wraps to WIDTH-1.
  - ptr changes only on a load.
- **Grant.** On a load, out_idx <= granted index, out_valid <= 1, and that bit is cleared in pending (subject to the set-wins rule).
- **Release.** Accept without a load (pending == 0) sets out_valid <= 0. out_idx is held.
- **Stall.** While out_valid && !out_ready, out_idx, out_valid and ptr are stable, and pending keeps accumulating.
- **Overflow.** overflow <= |(req_in & pending & ~grant_mask), registered.
  - A duplicate request is merged into one pending bit, never counted twice.
- **Reset values.** pending=0, out_valid=0, out_idx=0, overflow=0, ptr=WIDTH-1.
  - Reset mid-operation discards pending and the output, with no grant emitted.
  - req_in is ignored while reset is high.

## Timing
- Latency: req_in high in cycle t gives pending set after edge t+1, and out_valid/out_idx after edge t+2 if the output is free.
- Throughput: one grant per cycle while out_ready=1 and pending != 0. No bubble between back-to-back grants.
- overflow is valid in the cycle after the edge that sampled the duplicate.
- All outputs are registered; there is no combinational path from inputs to outputs.
- out_ready may be high while out_valid=0; it has no effect then.

## Test plan
- **Reset.** Hold reset 3 cycles with req_in=8'hFF -> after release: pending=0, out_valid=0, out_idx=0, overflow=0. First grant only after new requests.
- **Fixed order.** WIDTH=8, RR_MODE=0, out_ready=1. req_in=8'b1010_0100 for one cycle t -> out_valid high after edges t+2, t+3, t+4 with out_idx 7, 5, 2, then low. pending goes 8'hA4, 8'h24, 8'h04, 0.
- **Backpressure.** Same stimulus with out_ready=0 for 5 cycles -> out_idx=7 stable and pending=8'h24 held. Then out_ready=1 -> 5, 2 on consecutive cycles.
- **Mode contrast.** req_in=8'b1000_0001 held constant, out_ready=1.
  - RR_MODE=1 -> out_idx alternates 7, 0, 7, 0; overflow pulses from bit 7 or 0 while the other is granted.
  - RR_MODE=0 -> out_idx=7 every cycle and bit 0 starves; overflow=1 continuously once pending[0] is set.
- **Overflow merge.** Output stalled (out_valid=1, out_ready=0). req_in[3] pulses in two consecutive cycles -> overflow high exactly one cycle, pending[3]=1. After release, exactly one grant of 3.
- **Reset mid-op.** Pending 8'h0F with out_valid=1, idx 6. Assert reset one cycle -> all outputs at reset values, and no grant of 0..3 follows without new requests.
